// File: rtl/ipsl_pcie_dma_tx_tlp_arb.sv
// ipsl_pcie_dma_tx_tlp_arb
// Merges the CPLD (src0), MRD (src1) and MWR (src2) TLP streams of the DMA tx
// path onto the single AXI-Stream slave port of the PCIe core.
//  - Packet-atomic arbitration: a granted source owns the port until its tlast
//    beat is accepted. One IDLE bubble cycle separates consecutive packets.
//  - Round-robin by default; define IPSL_PCIE_DMA_TX_ARB_STRICT_PRIO_EN for
//    fixed priority src0 > src1 > src2 (no RR pointer in that build).
//  - A 2-entry skid buffer registers the output, so i_axis_trdy never reaches
//    the source trdy outputs combinationally.
//  - Per-source TLP counters for debug, cleared by i_tx_restart.
// Handshake: every stream is valid/ready; a beat transfers on the rising edge
// where tvld & trdy are both high. A source holds tdata/tlast/tuser while tvld
// is high and trdy is low, and may leave tvld low between beats of a packet.
// The FSM state is visible on o_grant: zero in IDLE, one-hot in BUSY.
`timescale 1ns/1ps
module ipsl_pcie_dma_tx_tlp_arb #(
  parameter int DATA_WIDTH = 128,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_src0_tvld,
  output logic                  o_src0_trdy,
  input  logic [DATA_WIDTH-1:0] i_src0_tdata,
  input  logic                  i_src0_tlast,
  input  logic                  i_src0_tuser,
  input  logic                  i_src1_tvld,
  output logic                  o_src1_trdy,
  input  logic [DATA_WIDTH-1:0] i_src1_tdata,
  input  logic                  i_src1_tlast,
  input  logic                  i_src1_tuser,
  input  logic                  i_src2_tvld,
  output logic                  o_src2_trdy,
  input  logic [DATA_WIDTH-1:0] i_src2_tdata,
  input  logic                  i_src2_tlast,
  input  logic                  i_src2_tuser,
  output logic                  o_axis_tvld,
  input  logic                  i_axis_trdy,
  output logic [DATA_WIDTH-1:0] o_axis_tdata,
  output logic                  o_axis_tlast,
  output logic                  o_axis_tuser,
  input  logic                  i_tx_restart,
  output logic                  o_busy,
  output logic [2:0]            o_grant,
  output logic [CNT_WIDTH-1:0]  o_tlp_cnt0,
  output logic [CNT_WIDTH-1:0]  o_tlp_cnt1,
  output logic [CNT_WIDTH-1:0]  o_tlp_cnt2
);

  // A beat is stored as {tuser, tlast, tdata}.
  localparam int BW = DATA_WIDTH + 2;

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [2:0]           req, pick, grant, trdy;
  logic [BW-1:0]        beat_in;
  logic                 accept, last_accept;
  logic [BW-1:0]        skid_mem0, skid_mem1;
  logic [1:0]           skid_cnt, skid_cnt_nxt, wr_slot;
  logic                 skid_not_full;
  logic                 push, pop;
  logic [CNT_WIDTH-1:0] cnt0, cnt1, cnt2;

  assign req = {i_src2_tvld, i_src1_tvld, i_src0_tvld};

`ifdef IPSL_PCIE_DMA_TX_ARB_STRICT_PRIO_EN
  // Fixed priority winner: CPLD first, then MRD, then MWR.
  always_comb begin
    pick = 3'b000;
    if (req[0])      pick = 3'b001;
    else if (req[1]) pick = 3'b010;
    else if (req[2]) pick = 3'b100;
  end
`else
  // Next source to be offered first; only values 0..2 are ever loaded.
  logic [1:0] rr_ptr;

  // Round-robin winner: scan cyclically starting at rr_ptr.
  always_comb begin
    pick = 3'b000;
    case (rr_ptr)
      2'd1: begin
        if (req[1])      pick = 3'b010;
        else if (req[2]) pick = 3'b100;
        else if (req[0]) pick = 3'b001;
      end
      2'd2: begin
        if (req[2])      pick = 3'b100;
        else if (req[0]) pick = 3'b001;
        else if (req[1]) pick = 3'b010;
      end
      default: begin
        if (req[0])      pick = 3'b001;
        else if (req[1]) pick = 3'b010;
        else if (req[2]) pick = 3'b100;
      end
    endcase
  end

  // Advance the pointer past the winner once its packet completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 2'd0;
    end else if (last_accept) begin
      if (grant[0])      rr_ptr <= 2'd1;
      else if (grant[1]) rr_ptr <= 2'd2;
      else               rr_ptr <= 2'd0;
    end
  end
`endif

  // Route the granted source's beat towards the skid buffer.
  always_comb begin
    beat_in = '0;
    if (grant[0])      beat_in = {i_src0_tuser, i_src0_tlast, i_src0_tdata};
    else if (grant[1]) beat_in = {i_src1_tuser, i_src1_tlast, i_src1_tdata};
    else if (grant[2]) beat_in = {i_src2_tuser, i_src2_tlast, i_src2_tdata};
  end

  assign accept      = |(trdy & req);
  assign last_accept = accept & beat_in[BW-2];

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: leave IDLE on any request, leave BUSY on the tlast accept.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|pick)      state_nxt = ST_BUSY;
      ST_BUSY: if (last_accept) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: only the granted source sees trdy, and only while there is room.
  always_comb begin
    trdy   = 3'b000;
    o_busy = (skid_cnt != 2'd0);
    if (state == ST_BUSY) begin
      o_busy = 1'b1;
      if (skid_not_full) trdy = grant;
    end
  end

  // Grant register: latch the winner in IDLE, drop it after the tlast accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant <= 3'b000;
    end else if (state == ST_IDLE) begin
      grant <= pick;
    end else if (last_accept) begin
      grant <= 3'b000;
    end
  end

  assign push         = accept;
  assign pop          = (skid_cnt != 2'd0) & i_axis_trdy;
  assign skid_cnt_nxt = skid_cnt + {1'b0, push} - {1'b0, pop};
  // Slot an incoming beat lands in, after any same-cycle pop has shifted.
  assign wr_slot      = skid_cnt - {1'b0, pop};

  // Skid buffer: entry 0 is the head driving the core, entry 1 the overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_mem0     <= '0;
      skid_mem1     <= '0;
      skid_cnt      <= 2'd0;
      skid_not_full <= 1'b1;
    end else begin
      skid_cnt      <= skid_cnt_nxt;
      skid_not_full <= (skid_cnt_nxt != 2'd2);
      if (push && wr_slot == 2'd0) skid_mem0 <= beat_in;
      else if (pop)                skid_mem0 <= skid_mem1;
      if (push && wr_slot == 2'd1) skid_mem1 <= beat_in;
    end
  end

  // Debug TLP counters; a restart in the same cycle as an increment wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
      cnt2 <= '0;
    end else if (i_tx_restart) begin
      cnt0 <= '0;
      cnt1 <= '0;
      cnt2 <= '0;
    end else if (last_accept) begin
      if (grant[0]) cnt0 <= cnt0 + 1'b1;
      if (grant[1]) cnt1 <= cnt1 + 1'b1;
      if (grant[2]) cnt2 <= cnt2 + 1'b1;
    end
  end

  assign o_src0_trdy  = trdy[0];
  assign o_src1_trdy  = trdy[1];
  assign o_src2_trdy  = trdy[2];
  assign o_axis_tvld  = (skid_cnt != 2'd0);
  assign o_axis_tuser = skid_mem0[BW-1];
  assign o_axis_tlast = skid_mem0[BW-2];
  assign o_axis_tdata = skid_mem0[DATA_WIDTH-1:0];
  assign o_grant      = grant;
  assign o_tlp_cnt0   = cnt0;
  assign o_tlp_cnt1   = cnt1;
  assign o_tlp_cnt2   = cnt2;

endmodule

// File: tb/tb_ipsl_pcie_dma_tx_tlp_arb.sv
// Testbench for ipsl_pcie_dma_tx_tlp_arb.
// A table of scenarios (packets per source, packet length, core-side ready
// pattern, source gaps, start delays, expected first grant) is replayed, then
// randomized scenarios, then hand-written restart and async-reset sequences.
// Every cycle the outputs are compared with a packet-level reference model:
// the grant follows the cyclic scan rule, the port is held per packet, the
// output stream is the FIFO of accepted beats, and counters count TLPs.
`timescale 1ns/1ps
module tb_ipsl_pcie_dma_tx_tlp_arb;

  localparam int DW   = 128;
  localparam int CW   = 16;
  localparam int BW   = DW + 2;
  localparam int MAXB = 256;

  typedef struct packed {
    logic [2:0][7:0] pkts;      // packets per source, [n] = src n
    logic [7:0]      beats;     // beats per packet, 0 = random 1..6
    logic [1:0]      mode;      // core ready: 0 always, 1 pattern 1,0,0,1, 2 random
    logic            gaps;      // sources may idle between beats
    logic [2:0][7:0] start;     // cycle at which each source may begin
    logic [2:0]      exp_first; // expected first grant, 0 = not checked
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    s_vld, s_last, s_user;
  logic [DW-1:0] s_data [3];
  logic          axis_trdy, restart;
  logic          o_src0_trdy, o_src1_trdy, o_src2_trdy;
  logic          o_axis_tvld, o_axis_tlast, o_axis_tuser, o_busy;
  logic [DW-1:0] o_axis_tdata;
  logic [2:0]    o_grant;
  logic [CW-1:0] o_tlp_cnt0, o_tlp_cnt1, o_tlp_cnt2;

  always #5 clk = ~clk;

  ipsl_pcie_dma_tx_tlp_arb #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_src0_tvld  (s_vld[0]),
    .o_src0_trdy  (o_src0_trdy),
    .i_src0_tdata (s_data[0]),
    .i_src0_tlast (s_last[0]),
    .i_src0_tuser (s_user[0]),
    .i_src1_tvld  (s_vld[1]),
    .o_src1_trdy  (o_src1_trdy),
    .i_src1_tdata (s_data[1]),
    .i_src1_tlast (s_last[1]),
    .i_src1_tuser (s_user[1]),
    .i_src2_tvld  (s_vld[2]),
    .o_src2_trdy  (o_src2_trdy),
    .i_src2_tdata (s_data[2]),
    .i_src2_tlast (s_last[2]),
    .i_src2_tuser (s_user[2]),
    .o_axis_tvld  (o_axis_tvld),
    .i_axis_trdy  (axis_trdy),
    .o_axis_tdata (o_axis_tdata),
    .o_axis_tlast (o_axis_tlast),
    .o_axis_tuser (o_axis_tuser),
    .i_tx_restart (restart),
    .o_busy       (o_busy),
    .o_grant      (o_grant),
    .o_tlp_cnt0   (o_tlp_cnt0),
    .o_tlp_cnt1   (o_tlp_cnt1),
    .o_tlp_cnt2   (o_tlp_cnt2)
  );

  // ---------------- source and model state ----------------
  logic [BW-1:0] src_mem [3][MAXB];
  int            src_len [3];
  int            src_idx [3];
  int            src_start [3];
  int            src_ser [3];
  int            cyc, mode;
  bit            gap_en, restart_arm, fg_armed;
  logic [2:0]    fg;

  logic [BW-1:0] exp_q[$];       // accepted beats not yet taken by the core
  logic [2:0]    m_grant;        // grant the port should show this cycle
  int            m_ptr;          // first source offered by the cyclic scan
  logic [CW-1:0] m_cnt [3];

  int n_tests = 0;
  int n_fail  = 0;

  vec_t tbl [6];
  vec_t rv;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Spec rule: first requester found scanning from the pointer (or lowest index).
  function automatic logic [2:0] pick(input logic [2:0] req, input int ptr);
    logic [2:0] w;
    int s;
    w = 3'b000;
    for (int k = 0; k < 3; k++) begin
`ifdef IPSL_PCIE_DMA_TX_ARB_STRICT_PRIO_EN
      s = k + (ptr & 0);
`else
      s = (ptr + k) % 3;
`endif
      if (w == 3'b000 && req[s]) w = 3'(1 << s);
    end
    return w;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_grant = 3'b000;
    m_ptr   = 0;
    for (int n = 0; n < 3; n++) begin
      m_cnt[n]   = '0;
      src_len[n] = 0;
      src_idx[n] = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load(input int n, input int npk, input int nbeats);
    logic [DW-1:0] d;
    int bl;
    src_len[n] = 0;
    src_idx[n] = 0;
    for (int p = 0; p < npk; p++) begin
      bl = (nbeats != 0) ? nbeats : int'($urandom_range(1, 6));
      for (int b = 0; b < bl; b++) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        d[31:0]  = src_ser[n];
        d[39:32] = 8'(n);
        src_ser[n]++;
        src_mem[n][src_len[n]] = {1'($urandom_range(0, 1)), (b == bl - 1), d};
        src_len[n]++;
      end
    end
  endtask

  // One clock: check at negedge and advance the model, then drive after posedge.
  task automatic tick();
    logic [2:0] trdy_v, acc, trdy_exp;
    int done_n;
    @(negedge clk);
    trdy_v   = {o_src2_trdy, o_src1_trdy, o_src0_trdy};
    acc      = s_vld & trdy_v;
    trdy_exp = (exp_q.size() < 2) ? m_grant : 3'b000;
    chk("grant", BW'(o_grant), BW'(m_grant));
    chk("src_trdy", BW'(trdy_v), BW'(trdy_exp));
    chk("out_tvld", BW'(o_axis_tvld), BW'(exp_q.size() != 0));
    if (exp_q.size() != 0)
      chk("out_beat", {o_axis_tuser, o_axis_tlast, o_axis_tdata}, exp_q[0]);
    chk("busy", BW'(o_busy), BW'((m_grant != 3'b000) || (exp_q.size() != 0)));
    chk("tlp_cnt", BW'({o_tlp_cnt2, o_tlp_cnt1, o_tlp_cnt0}), BW'({m_cnt[2], m_cnt[1], m_cnt[0]}));
    if (fg_armed && o_grant != 3'b000) begin
      fg       = o_grant;
      fg_armed = 1'b0;
    end
    if (exp_q.size() != 0 && axis_trdy) void'(exp_q.pop_front());
    done_n = -1;
    for (int n = 0; n < 3; n++) begin
      if (acc[n] && m_grant[n]) begin
        exp_q.push_back({s_user[n], s_last[n], s_data[n]});
        if (s_last[n]) done_n = n;
      end
    end
    if (restart) begin
      for (int n = 0; n < 3; n++) m_cnt[n] = '0;
    end else if (done_n >= 0) begin
      m_cnt[done_n] = m_cnt[done_n] + 1'b1;
    end
    if (m_grant == 3'b000) begin
      m_grant = pick(s_vld, m_ptr);
    end else if (done_n >= 0) begin
      m_grant = 3'b000;
      m_ptr   = (done_n + 1) % 3;
    end

    @(posedge clk);
    #1;
    for (int n = 0; n < 3; n++) begin
      if (acc[n]) src_idx[n]++;
      if (acc[n] || !s_vld[n]) begin
        if (src_idx[n] < src_len[n] && cyc >= src_start[n] &&
            (!gap_en || $urandom_range(0, 3) != 0)) begin
          s_vld[n] = 1'b1;
          {s_user[n], s_last[n], s_data[n]} = src_mem[n][src_idx[n]];
        end else begin
          s_vld[n] = 1'b0;
        end
      end
    end
    case (mode)
      1:       axis_trdy = (cyc % 4 == 0) || (cyc % 4 == 3);
      2:       axis_trdy = ($urandom_range(0, 2) != 0);
      default: axis_trdy = 1'b1;
    endcase
    restart = restart_arm && s_vld[2] && s_last[2] && o_src2_trdy;
    if (restart) restart_arm = 1'b0;
    cyc++;
  endtask

  // Assert reset between edges, check outputs clear at once, then release.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n   = 1'b0;
    s_vld   = 3'b000;
    s_last  = 3'b000;
    s_user  = 3'b000;
    restart = 1'b0;
    #1;
    chk("rst_ctrl", BW'({o_axis_tvld, o_axis_tlast, o_axis_tuser, o_busy, o_grant,
                        o_src2_trdy, o_src1_trdy, o_src0_trdy}), '0);
    chk("rst_data", BW'(o_axis_tdata), '0);
    chk("rst_cnt", BW'({o_tlp_cnt2, o_tlp_cnt1, o_tlp_cnt0}), '0);
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input bit rs);
    bit done;
    int budget;
    for (int n = 0; n < 3; n++) begin
      src_ser[n]   = 0;
      load(n, int'(v.pkts[n]), int'(v.beats));
      src_start[n] = int'(v.start[n]);
    end
    mode        = int'(v.mode);
    gap_en      = v.gaps;
    restart_arm = rs;
    cyc         = 0;
    fg_armed    = 1'b1;
    fg          = 3'b000;
    done        = 1'b0;
    budget      = 0;
    while (!done && budget < 4000) begin
      tick();
      budget++;
      done = (src_idx[0] == src_len[0]) && (src_idx[1] == src_len[1]) &&
             (src_idx[2] == src_len[2]) && (s_vld == 3'b000) &&
             (exp_q.size() == 0) && (m_grant == 3'b000);
    end
    chk("drain", BW'(done), BW'(1'b1));
  endtask

  task automatic chk_counts(input string nm, input vec_t v);
    chk(nm, BW'({o_tlp_cnt2, o_tlp_cnt1, o_tlp_cnt0}),
        BW'({CW'(v.pkts[2]), CW'(v.pkts[1]), CW'(v.pkts[0])}));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    rst_n     = 1'b0;
    s_vld     = 3'b000;
    s_last    = 3'b000;
    s_user    = 3'b000;
    for (int n = 0; n < 3; n++) s_data[n] = '0;
    axis_trdy = 1'b1;
    restart   = 1'b0;
    mode      = 0;
    gap_en    = 1'b0;
    model_clear();

    // single packet, round-robin, backpressure, atomicity, random mixes
    tbl[0] = '{pkts: {8'd1, 8'd0, 8'd0}, beats: 8'd3, mode: 2'd0, gaps: 1'b0,
               start: {8'd0, 8'd0, 8'd0}, exp_first: 3'b100};
    tbl[1] = '{pkts: {8'd2, 8'd2, 8'd2}, beats: 8'd2, mode: 2'd0, gaps: 1'b0,
               start: {8'd0, 8'd0, 8'd0}, exp_first: 3'b001};
    tbl[2] = '{pkts: {8'd0, 8'd1, 8'd0}, beats: 8'd8, mode: 2'd1, gaps: 1'b0,
               start: {8'd0, 8'd0, 8'd0}, exp_first: 3'b010};
    tbl[3] = '{pkts: {8'd1, 8'd1, 8'd1}, beats: 8'd4, mode: 2'd0, gaps: 1'b0,
               start: {8'd3, 8'd3, 8'd0}, exp_first: 3'b001};
    tbl[4] = '{pkts: {8'd4, 8'd3, 8'd5}, beats: 8'd0, mode: 2'd2, gaps: 1'b1,
               start: {8'd0, 8'd0, 8'd0}, exp_first: 3'b000};
    tbl[5] = '{pkts: {8'd6, 8'd6, 8'd6}, beats: 8'd0, mode: 2'd2, gaps: 1'b0,
               start: {8'd0, 8'd0, 8'd0}, exp_first: 3'b001};

    for (int i = 0; i < 6; i++) begin
      do_reset();
      run_vec(tbl[i], 1'b0);
      if (tbl[i].exp_first != 3'b000) chk("first_grant", BW'(fg), BW'(tbl[i].exp_first));
      chk_counts("final_cnt", tbl[i]);
    end

    // randomized mixes
    for (int r = 0; r < 4; r++) begin
      rv.pkts      = {8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)), 8'($urandom_range(0, 5))};
      rv.beats     = 8'd0;
      rv.mode      = 2'd2;
      rv.gaps      = 1'($urandom_range(0, 1));
      rv.start     = {8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)), 8'($urandom_range(0, 4))};
      rv.exp_first = 3'b000;
      do_reset();
      run_vec(rv, 1'b0);
      chk_counts("rand_cnt", rv);
    end

    // restart coincident with a src2 tlast accept after counters reach 5/3/7
    do_reset();
    rv = '{pkts: {8'd7, 8'd3, 8'd5}, beats: 8'd2, mode: 2'd0, gaps: 1'b0,
           start: {8'd0, 8'd0, 8'd0}, exp_first: 3'b001};
    run_vec(rv, 1'b0);
    chk_counts("cnt_5_3_7", rv);
    rv = '{pkts: {8'd1, 8'd0, 8'd0}, beats: 8'd3, mode: 2'd0, gaps: 1'b0,
           start: {8'd0, 8'd0, 8'd0}, exp_first: 3'b100};
    run_vec(rv, 1'b1);
    chk("restart_fired", BW'(restart_arm), BW'(1'b0));
    chk("cnt_after_restart", BW'({o_tlp_cnt2, o_tlp_cnt1, o_tlp_cnt0}), '0);

    // async reset in the middle of a src0 packet, then all three request
    do_reset();
    for (int n = 0; n < 3; n++) begin
      src_ser[n]   = 0;
      src_start[n] = 0;
    end
    load(0, 1, 6);
    load(1, 0, 2);
    load(2, 0, 2);
    mode     = 0;
    gap_en   = 1'b0;
    cyc      = 0;
    fg_armed = 1'b0;
    repeat (5) tick();
    chk("mid_pkt_busy", BW'(o_busy), BW'(1'b1));
    do_reset();
    rv = '{pkts: {8'd1, 8'd1, 8'd1}, beats: 8'd2, mode: 2'd0, gaps: 1'b0,
           start: {8'd0, 8'd0, 8'd0}, exp_first: 3'b001};
    run_vec(rv, 1'b0);
    chk("grant_after_reset", BW'(fg), BW'(3'b001));
    chk_counts("cnt_after_reset", rv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ipsl_pcie_dma_tx_tlp_arb.md
Name: ipsl_pcie_dma_tx_tlp_arb

Overview:
- Merges the three TLP streams from the DMA tx path (CPLD, MRD and MWR generators) onto the single AXI-Stream slave port of the PCIe core.
- Arbitration is packet-atomic: once a source is granted, it keeps the port until its tlast beat is accepted.
- Default policy is round-robin; strict priority is available as a compile option.
- A 2-entry skid buffer registers the output, so the core-side trdy never reaches the sources combinationally.
- Per-source TLP counters are provided for debug.

Parameters:
- DATA_WIDTH, 128, AXIS tdata width.
- CNT_WIDTH, 16, width of each per-source TLP counter.

Ports:
- clk  input  1  user clock (gen1 62.5MHz, gen2 125MHz)
- rst_n  input  1  asynchronous active-low reset
- i_src0_tvld / o_src0_trdy / i_src0_tdata / i_src0_tlast / i_src0_tuser  in/out/in/in/in  1/1/DATA_WIDTH/1/1  CPLD stream
- i_src1_tvld / o_src1_trdy / i_src1_tdata / i_src1_tlast / i_src1_tuser  same  same  MRD stream
- i_src2_tvld / o_src2_trdy / i_src2_tdata / i_src2_tlast / i_src2_tuser  same  same  MWR stream
- o_axis_tvld  output  1  to core slave
- i_axis_trdy  input  1  from core
- o_axis_tdata  output  DATA_WIDTH
- o_axis_tlast  output  1
- o_axis_tuser  output  1
- i_tx_restart  input  1  synchronous clear of the debug counters
- o_busy  output  1  high while in BUSY or while the skid buffer holds data
- o_grant  output  3  one-hot current grant; 0 when IDLE
- o_tlp_cnt0/1/2  output  CNT_WIDTH each  TLPs forwarded per source

Behaviour:
Reset:
- All outputs go to 0 and o_src*_trdy=0.
- State=IDLE, skid buffer empty, RR pointer=0, counters=0.

State machine, IDLE:
- Choose the winner among asserted i_srcN_tvld, starting at the RR pointer and scanning 0->1->2 cyclically.
- On the next edge, register o_grant to the one-hot winner and go to BUSY.
- No request: stay in IDLE, o_grant=0.
- The IDLE cycle gives exactly one bubble cycle between packets. This is accepted.

State machine, BUSY:
- o_srcN_trdy = grant[N] & skid_not_full; every other source sees trdy=0.
- Beat accept = granted tvld & trdy. The beat (tdata/tlast/tuser) is written to the skid buffer.
- On the accepted tlast beat: on the next edge go to IDLE, set RR pointer = winner+1 mod 3, and increment o_tlp_cntN.
- Requests from other sources during BUSY are ignored and never interrupt the packet.
- A granted source may drop tvld mid-packet. The grant is held indefinitely; there is no timeout.

Skid buffer:
- 2 entries.
- skid_not_full is registered: high while occupancy < 2.
- Latency: a beat accepted at edge k appears on o_axis_* after edge k, i.e. one cycle of latency.
- Output beat pops on o_axis_tvld & i_axis_trdy. Push and pop in the same cycle leave occupancy unchanged.
- Full throughput of 1 beat/cycle is sustained while i_axis_trdy=1.
- Output data holds stable while tvld=1 and trdy=0.
- Beat order is preserved; beats are never dropped or duplicated.

Counters:
- Wrap at 2^CNT_WIDTH.
- i_tx_restart clears all counters to 0 on the next edge. If restart coincides with an increment, the restart wins and the counter reads 0.
- Restart does not affect arbitration or data.

Width and encoding rules:
- RR pointer is 2 bits, values 0..2; value 3 is unreachable.
- o_grant is always one-hot or zero.

Reset mid-packet:
- Everything returns to the reset state, including discarding skid contents. The sources are reset by the same rst_n.

Optional Feature:
IPSL_PCIE_DMA_TX_ARB_STRICT_PRIO_EN:
- Defined: IDLE picks by fixed priority src0 (CPLD) > src1 (MRD) > src2 (MWR). The RR pointer is not instantiated. Packet atomicity is unchanged.
- Undefined: round-robin as above.

Test Plan:
- Single packet: src2 sends a 3-beat TLP (data A,B,C; tlast on C) with i_axis_trdy=1 -> o_grant=3'b100 one cycle after tvld; A,B,C appear on consecutive cycles, 1 cycle after acceptance; tlast only on C; o_tlp_cnt2=1; o_busy falls after C drains.
- Round-robin: all three sources hold 2-beat TLPs continuously after reset -> grant sequence 001,010,100,001 with exactly one IDLE bubble between packets; after 6 packets each counter=2. With STRICT_PRIO_EN the grant stays 001 for as long as src0 keeps requesting.
- Backpressure: src1 sends 8 beats of incrementing data while i_axis_trdy toggles 1,0,0,1 repeating -> output sequence exactly 0..7 with no loss or duplication; data stable while stalled; o_src1_trdy falls when the skid reaches 2 entries.
- Atomicity: while src0 is mid-packet (beat 2 of 4), src1 and src2 assert tvld -> o_src1_trdy and o_src2_trdy stay 0 until src0's tlast is accepted; the next grant is 010.
- Restart: after the counters reach 5/3/7, assert i_tx_restart for 1 cycle coincident with a src2 tlast accept -> all counters read 0 on the next cycle; the forwarded packet is still complete on the output.
- Async reset: assert rst_n=0 mid-packet between edges -> all outputs are 0 immediately; after release, state is IDLE and the first grant goes to src0 when all sources request.
